// File: rtl/test7_mux8.sv
// Registered 8-to-1 word multiplexer: Y takes the input
// chosen by SEL one sys_clk edge after sampling.
module test7_mux8 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] E,
  input  logic [WIDTH-1:0] F,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] H,
  input  logic [2:0]       SEL,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;

  // Unknown SEL in simulation yields zero rather than X.
  always_comb begin
    y_d = '0;
    case (SEL)
      3'd0:    y_d = A;
      3'd1:    y_d = B;
      3'd2:    y_d = C;
      3'd3:    y_d = D;
      3'd4:    y_d = E;
      3'd5:    y_d = F;
      3'd6:    y_d = G;
      3'd7:    y_d = H;
      default: y_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_test7_mux8.sv
// Directed and random checks of test7_mux8 against an
// array-indexed reference model.
module tb_test7_mux8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic [7:0] din [8];
  logic [2:0] sel;
  logic [7:0] y;
  logic [7:0] exp_y;
  int         tests = 0;
  int         fails = 0;

  always #10 sys_clk = ~sys_clk;

  test7_mux8 #(.WIDTH(8)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .A         (din[0]),
    .B         (din[1]),
    .C         (din[2]),
    .D         (din[3]),
    .E         (din[4]),
    .F         (din[5]),
    .G         (din[6]),
    .H         (din[7]),
    .SEL       (sel),
    .Y         (y)
  );

  task automatic chk(input string tag, input logic [7:0] e);
    tests++;
    assert (y === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, y, e);
    end
  endtask

  task automatic edge1;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 8; i++) din[i] = v;
  endtask

  initial begin
    fill(8'd10);
    sel = 3'd0;
    #2 sys_rst_n = 1'b0;
    #3 chk("reset_async", 8'h00);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("reset_hold", 8'h00);
    end

    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 8'((i + 1) * 8'h11);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      exp_y = din[sel];
      edge1();
      chk("walk_sel", exp_y);
    end

    sel = 3'd3;
    din[3] = 8'h00;
    edge1();
    chk("lat_before", 8'h00);
    #5 din[3] = 8'hFF;
    #2 chk("lat_midcycle", 8'h00);
    edge1();
    chk("lat_after", 8'hFF);

    fill(8'hFF);
    sel = 3'd7;
    edge1();
    chk("bound_ff", 8'hFF);
    fill(8'h00);
    sel = 3'd0;
    edge1();
    chk("bound_00", 8'h00);

    sel = 3'd2;
    din[2] = 8'hA5;
    edge1();
    chk("midrst_pre", 8'hA5);
    #5 sys_rst_n = 1'b0;
    #1 chk("midrst_async", 8'h00);
    edge1();
    chk("midrst_hold", 8'h00);
    sys_rst_n = 1'b1;
    edge1();
    chk("midrst_release", 8'hA5);

    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom_range(0, 255));
      sel = 3'($urandom_range(0, 7));
      exp_y = din[sel];
      edge1();
      chk("random", exp_y);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
